// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU bus arbiter.
// Copies LENGTH bytes from {src,00} into FE00 and blocks the low bus while busy.
module oam_dma_arbiter #(
  parameter int          LENGTH  = 160,
  parameter logic [15:0] DMA_REG = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic [7:0]  cpu_d_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  input  logic [7:0]  bus_d_in,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_d_out,
  output logic        io_write,
  input  logic [7:0]  io_d_in,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST = 8'(LENGTH - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] src;
  logic [7:0] idx;
  logic [7:0] data;
  logic [7:0] eff_src;
  logic       trig;
  logic       last;
  logic       hi_page;

  assign trig    = cpu_write && (cpu_addr == DMA_REG);
  assign hi_page = (cpu_addr >= 16'hFF00);
  // idx never passes LAST, so equality is the end-of-block test
  assign last    = (idx == LAST);
  // Echo RAM E000-FDFF mirrors C000-DDFF
  assign eff_src = (src >= 8'hE0) ? (src - 8'h20) : src;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; a trigger restarts from any state
  always_comb begin
    state_nx = state;
    if (trig) begin
      state_nx = START;
    end else begin
      unique case (state)
        IDLE:  state_nx = IDLE;
        START: state_nx = READ;
        READ:  state_nx = WRITE;
        WRITE: state_nx = last ? IDLE : READ;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Source page, byte index and the byte in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      src  <= 8'h00;
      idx  <= 8'h00;
      data <= 8'h00;
    end else begin
      if (state == READ) data <= bus_d_in;
      if (trig) begin
        src <= cpu_d_out;
        idx <= 8'h00;
      end else if (state == WRITE) begin
        idx <= last ? 8'h00 : idx + 8'd1;
      end
    end
  end

  // Low bus mux: CPU pass-through when idle, DMA otherwise
  always_comb begin
    bus_addr  = cpu_addr;
    bus_d_out = cpu_d_out;
    bus_write = 1'b0;
    unique case (state)
      IDLE:  bus_write = cpu_write && !hi_page;
      START: bus_write = 1'b0;
      READ:  bus_addr  = {eff_src, idx};
      WRITE: begin
        bus_addr  = {8'hFE, idx};
        bus_d_out = data;
        bus_write = 1'b1;
      end
      default: bus_write = 1'b0;
    endcase
  end

  assign busy = (state != IDLE);

  // High page is never blocked by DMA
  assign io_addr  = cpu_addr[7:0];
  assign io_d_out = cpu_d_out;
  assign io_write = cpu_write && hi_page && (cpu_addr != DMA_REG);

  // CPU read-back mux
  always_comb begin
    if (cpu_addr == DMA_REG) cpu_d_in = src;
    else if (hi_page)        cpu_d_in = io_d_in;
    else if (busy)           cpu_d_in = 8'hFF;
    else                     cpu_d_in = bus_d_in;
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter.
// Bus writes are checked against a queue of expected writes.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_d_out = 8'h00;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic [7:0]  bus_d_in;
  logic [7:0]  io_addr;
  logic [7:0]  io_d_out;
  logic        io_write;
  logic [7:0]  io_d_in;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic [23:0] sb [$];
  int          checks = 0;
  int          failures = 0;

  oam_dma_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_d_out (cpu_d_out),
    .cpu_write (cpu_write),
    .cpu_d_in  (cpu_d_in),
    .bus_addr  (bus_addr),
    .bus_d_out (bus_d_out),
    .bus_write (bus_write),
    .bus_d_in  (bus_d_in),
    .io_addr   (io_addr),
    .io_d_out  (io_d_out),
    .io_write  (io_write),
    .io_d_in   (io_d_in),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory model
  assign bus_d_in = mem[bus_addr];
  assign io_d_in  = io_addr ^ 8'h3C;

  always @(posedge clk) begin
    if (bus_write === 1'b1) mem[bus_addr] <= bus_d_out;
  end

  // Monitor: every bus write must match the head of the queue
  always @(negedge clk) begin
    if (bus_write === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%h:%h required=none",
                 bus_addr, bus_d_out);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if ({bus_addr, bus_d_out} !== e) begin
          failures++;
          $display("FAIL bus_write actual=%h:%h required=%h:%h",
                   bus_addr, bus_d_out, e[23:8], e[7:0]);
        end
      end
    end
  end

  function automatic logic [7:0] pat(input logic [7:0] pg,
                                     input logic [7:0] i);
    return i ^ pg ^ 8'h9B;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_addr  = 16'h0000;
    cpu_d_out = 8'h00;
    cpu_write = 1'b0;
  endtask

  task automatic load_page(input logic [7:0] pg);
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = pat(pg, 8'(i));
  endtask

  task automatic push_xfer(input logic [7:0] pg, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back({8'hFE, 8'(i), pat(pg, 8'(i))});
  endtask

  task automatic trigger(input logic [7:0] s);
    cpu_addr  = 16'hFF46;
    cpu_d_out = s;
    cpu_write = 1'b1;
    cyc();
    idle_in();
  endtask

  // Runs until busy drops; optional re-trigger, reset and CPU pokes
  task automatic run(input int trig_at, input logic [7:0] tsrc,
                     input int rst_at, input bit poke,
                     input logic [15:0] rd_base,
                     input int exp_total, input int exp_after);
    int k;
    int start;
    bit fin;
    k = 0;
    start = 0;
    while (busy && k < 2000) begin
      idle_in();
      fin = (trig_at < 0) || (k > trig_at);
      if (k == trig_at) begin
        cpu_addr  = 16'hFF46;
        cpu_d_out = tsrc;
        cpu_write = 1'b1;
        start     = k + 1;
      end
      if (k == rst_at) rst = 1'b1;
      if (poke) begin
        case (k)
          10: cpu_addr = 16'h8000;
          20: cpu_addr = 16'hFF80;
          30: cpu_addr = 16'hFF46;
          40, 41: begin
            cpu_addr  = 16'hC000;
            cpu_d_out = 8'h77;
            cpu_write = 1'b1;
          end
          default: ;
        endcase
      end
      #1;
      if (poke && k == 10) chk("rd_8000_busy", cpu_d_in, 8'hFF);
      if (poke && k == 20) chk("rd_ff80_busy", cpu_d_in, 8'hBC);
      if (poke && k == 30) chk("rd_ff46", cpu_d_in, 8'hC1);
      if (poke && k == 41) chk("cpu_wr_blocked", bus_write, 1'b0);
      if (fin && k == start + 1)
        chk("rd_addr_first", bus_addr, rd_base);
      if (fin && k == start + 319)
        chk("rd_addr_last", bus_addr, rd_base + 16'd159);
      k++;
      cyc();
      rst = 1'b0;
    end
    if (busy) begin
      failures++;
      $display("FAIL busy_timeout actual=%0d required=%0d", k, exp_total);
    end
    idle_in();
    chk("busy_total", k, exp_total);
    chk("busy_after_trig", k - start, exp_after);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hC000] = 8'h11;
    load_page(8'hC1);
    load_page(8'hC2);
    load_page(8'h10);
    load_page(8'hD0);
    load_page(8'h20);
    load_page(8'h30);
    load_page(8'h40);

    // Reset wins over a simultaneous trigger
    cyc();
    cpu_addr  = 16'hFF46;
    cpu_d_out = 8'h99;
    cpu_write = 1'b1;
    cyc();
    rst = 1'b0;
    idle_in();
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_bus_write", bus_write, 1'b0);
    cpu_addr = 16'hFF46;
    #1;
    chk("reset_src", cpu_d_in, 8'h00);

    // High-page write goes to io only
    cpu_addr  = 16'hFF80;
    cpu_d_out = 8'h12;
    cpu_write = 1'b1;
    #1;
    chk("io_write", io_write, 1'b1);
    chk("io_no_bus", bus_write, 1'b0);
    cyc();
    idle_in();

    // Basic transfer with CPU accesses while busy
    push_xfer(8'hC1, 160);
    trigger(8'hC1);
    run(-1, 8'h00, -1, 1'b1, 16'hC100, 321, 321);
    chk("busy_dropped", busy, 1'b0);
    chk("fe9f_data", mem[16'hFE9F], 8'hC5);
    chk("c000_unchanged", mem[16'hC000], 8'h11);

    // Echo remap: E2 reads C2xx
    push_xfer(8'hC2, 160);
    trigger(8'hE2);
    run(-1, 8'h00, -1, 1'b0, 16'hC200, 321, 321);

    // Re-trigger at READ of idx 50
    push_xfer(8'h10, 50);
    push_xfer(8'hD0, 160);
    trigger(8'h10);
    run(101, 8'hD0, -1, 1'b0, 16'hD000, 423, 321);

    // Trigger on the final WRITE cycle
    push_xfer(8'h20, 160);
    push_xfer(8'h30, 160);
    trigger(8'h20);
    run(320, 8'h30, -1, 1'b0, 16'h3000, 642, 321);

    // Reset at READ of idx 80
    push_xfer(8'h40, 80);
    trigger(8'h40);
    run(-1, 8'h00, 161, 1'b0, 16'h4000, 162, 162);
    repeat (4) cyc();
    chk("sb_drained", sb.size(), 0);
    chk("fe4f_written", mem[16'hFE4F], pat(8'h40, 8'h4F));
    chk("fe50_untouched", mem[16'hFE50], pat(8'h30, 8'h50));
    chk("fe80_untouched", mem[16'hFE80], pat(8'h30, 8'h80));

    // CPU write passes through after reset
    sb.push_back({16'h8000, 8'h5E});
    cpu_addr  = 16'h8000;
    cpu_d_out = 8'h5E;
    cpu_write = 1'b1;
    #1;
    chk("pass_bus_write", bus_write, 1'b1);
    cyc();
    idle_in();
    cyc();
    chk("mem_8000", mem[16'h8000], 8'h5E);
    chk("sb_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter LENGTH, default 160, giving the number of bytes copied per transfer.
REQ-002 SHALL have parameter DMA_REG, default 16'hFF46, giving the DMA start/source register address.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high, sampled on the clk rising edge.
REQ-005 SHALL have port cpu_addr  input  16  CPU address.
REQ-006 SHALL have port cpu_d_out  input  8  CPU write data.
REQ-007 SHALL have port cpu_write  input  1  CPU write strobe.
REQ-008 SHALL have port cpu_d_in  output  8  read data returned to the CPU.
REQ-009 SHALL have port bus_addr  output  16  main-bus address for 0000-FEFF.
REQ-010 SHALL have port bus_d_out  output  8  main-bus write data.
REQ-011 SHALL have port bus_write  output  1  main-bus write strobe.
REQ-012 SHALL have port bus_d_in  input  8  main-bus read data.
REQ-013 SHALL have port io_addr  output  8  low byte of the high-page address, FF00-FFFF.
REQ-014 SHALL have port io_d_out  output  8  high-page write data.
REQ-015 SHALL have port io_write  output  1  high-page write strobe.
REQ-016 SHALL have port io_d_in  input  8  high-page read data.
REQ-017 SHALL have port busy  output  1  high while a transfer is in progress.

Function
REQ-018 SHALL implement the FSM states IDLE, START, READ and WRITE, with registers src[7:0], idx[7:0] and data[7:0].
REQ-019 SHALL treat a rising edge with cpu_write=1 and cpu_addr=DMA_REG, in any state, as a trigger: src<=cpu_d_out, idx<=0, state<=START.
REQ-020 SHALL sequence states as: START -> READ; READ -> WRITE; WRITE -> READ with idx<=idx+1 if idx<LENGTH-1, else WRITE -> IDLE with idx<=0.
REQ-021 SHALL, in READ, drive bus_addr={eff_src, idx} and bus_write=0, and capture data<=bus_d_in at the cycle's rising edge.
REQ-022 SHALL form eff_src as src-8'h20 when src>=8'hE0, else src.
REQ-023 SHALL, in WRITE, drive bus_addr=16'hFE00+idx, bus_d_out=data and bus_write=1.
REQ-024 SHALL, in START, drive bus_write=0 and bus_addr=cpu_addr.
REQ-025 SHALL, in IDLE, drive bus_addr=cpu_addr, bus_d_out=cpu_d_out and bus_write=cpu_write&(cpu_addr<16'hFF00).
REQ-026 SHALL assert busy combinationally whenever state!=IDLE.
REQ-027 SHALL make a complete transfer hold busy for exactly 1+2*LENGTH cycles (321 at default).
REQ-028 SHALL route the high page independent of state: io_addr=cpu_addr[7:0], io_d_out=cpu_d_out, io_write=cpu_write&(cpu_addr>=16'hFF00)&(cpu_addr!=DMA_REG).
REQ-029 SHALL form cpu_d_in with this priority: cpu_addr==DMA_REG -> src; cpu_addr>=16'hFF00 -> io_d_in; busy -> 8'hFF; else bus_d_in.
REQ-030 SHALL drop a CPU write to 0000-FEFF while busy, with no effect on any output or register.
REQ-031 SHALL handle a re-trigger during READ or WRITE by abandoning the current byte and restarting per REQ-019, so busy stays high continuously.
REQ-032 SHALL accept a trigger in the same cycle the last WRITE completes; the trigger wins and state becomes START, not IDLE.
REQ-033 SHALL keep idx within 8 bits and never exceed LENGTH-1.
REQ-034 SHALL support LENGTH values from 1 to 256.

Reset
REQ-035 SHALL, on rst=1 at a rising edge, set state=IDLE, src=8'h00, idx=0 and data=8'h00, overriding any simultaneous trigger.
REQ-036 SHALL, after reset mid-transfer, deassert busy the following cycle, perform no further DMA bus writes, and leave the partially written FE00 region untouched.
REQ-037 SHALL make all outputs combinational from state and the CPU inputs, so that after reset they follow the IDLE pass-through rules.

Verification
REQ-038 SHALL cover: write 8'hC1 to FF46, with memory C100+i = i ^ 8'h5A -> FE00+i = i ^ 8'h5A for i=0..159, busy high for exactly 321 cycles, then 0.
REQ-039 SHALL cover: CPU reads 8000 while busy -> cpu_d_in=8'hFF; CPU reads FF80 while busy -> io_d_in is returned; CPU reads FF46 -> 8'hC1.
REQ-040 SHALL cover: CPU writes C000 while busy -> no bus_write attributable to the CPU, and C000 unchanged after completion.
REQ-041 SHALL cover: trigger 8'hE2 -> READ addresses C200..C29F (echo remap).
REQ-042 SHALL cover: re-trigger with 8'hD0 at idx=50 -> the next READ is D000, and busy stays high 321 cycles from the re-trigger.
REQ-043 SHALL cover: rst pulse at idx=80 -> busy=0 the next cycle, no bus_write afterwards, and a CPU write to 8000 passes through to the bus.
